sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream loader for the SHA-256 message store. Accepts the message as a byte stream over a valid/ready handshake.
- Writes the bytes into the byte-addressed message RAM, then appends standard SHA-256 padding: 0x80, zero fill, and the 64-bit big-endian bit length.
- Reports the number of 512-bit blocks to the compression controller.
- Emits one RAM write per cycle; the RAM's 32-bit word read port is untouched by this block.

Parameters:
- RAM_BYTES, 1024: depth of the message RAM in bytes; must be a multiple of 64.
- MAX_MSG_BYTES, RAM_BYTES-9: largest message that still fits with padding (1015 at default).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse; begins a new message; honoured only in IDLE, DONE or ERROR
- in_valid  in  1  in_data holds a message byte
- in_data  in  8  message byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_end  in  1  single-cycle end-of-message strobe; honoured only in LOAD
- ram_we  out  1  RAM write enable
- ram_waddr  out  10  RAM byte address
- ram_wdata  out  8  RAM write byte
- busy  out  1  high in LOAD, PAD80, PADZERO and LEN
- done  out  1  one-cycle pulse; padded message complete in RAM
- num_blocks  out  5  block count (1..16); valid from done until next start
- err  out  1  sticky overflow flag; cleared by start or rst

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter n=0.
- States: IDLE, LOAD, PAD80, PADZERO, LEN, DONE, ERROR.
- IDLE/DONE/ERROR + start -> LOAD; clears n, err and num_blocks.
- LOAD:
  - in_ready=1.
  - Each accepted byte: ram_we=1, ram_waddr=n, ram_wdata=in_data in the same cycle (combinational from the handshake); n increments.
  - in_end seen -> PAD80. If in_end coincides with an accepted byte, that byte is written first and counted.
  - An accepted byte when n==MAX_MSG_BYTES is not written; err=1; state -> ERROR.
- PAD80: writes 0x80 at address n. Next state is LEN if (n+1) mod 64 == 56, else PADZERO.
- PADZERO: writes 0x00 at addresses n+1 up to the next address a with a mod 64 == 56, exclusive of a.
- LEN:
  - Eight writes at a..a+7 of the value L = 8*n, big-endian, 64-bit.
  - Bytes a..a+5 are 0x00; a+6 = L[15:8]; a+7 = L[7:0].
  - L never exceeds 13 bits at default size.
- After the last LEN write: state DONE; done pulses for one cycle; num_blocks = (a+8)/64.
- Write count after in_end = padded_len - n, where padded_len = 64*ceil((n+9)/64).
- No RAM write occurs outside LOAD handshakes and the PAD80, PADZERO and LEN states.
- in_ready=0 in every state except LOAD.
- Address width: counters 11 bits internally; ram_waddr carries the low 10 bits. Addresses never wrap because of the MAX_MSG_BYTES check.
- Zero-length message: start then in_end with no bytes. Writes 0x80 at 0, zeros 1..55, length bytes 56..63 all 0x00; num_blocks=1.
- start while busy is ignored. in_end outside LOAD is ignored. in_valid outside LOAD is not acknowledged.
- rst mid-operation: immediate return to IDLE, outputs 0. RAM contents are undefined for the consumer.
- ERROR: in_ready=0; no writes; waits for start.

Optional Feature:
- Macro SHA_PAD_LEN_OUT_EN.
- Defined: adds output msg_len_bytes [10:0]. It equals n, updates with done, is held until the next start, and resets to 0.
- Undefined: the port does not exist; no extra logic.

Test Plan:
- "abc" (0x61,0x62,0x63) then in_end -> writes at 0..2 are the data; 0x80@3; 0x00@4..62; 0x18@63; num_blocks=1; done one cycle after the addr-63 write.
- Empty message (start, in_end) -> 0x80@0; 0x00@1..63; num_blocks=1; exactly 64 writes.
- 56 bytes with in_end coincident with byte 56 -> 0x80@56; zeros 57..119; 0x01@126; 0xC0@127; num_blocks=2.
- 1015 bytes -> 0x80@1015; 0x1F@1022; 0xB8@1023; num_blocks=16; err=0. 1016 bytes -> err=1, no write to 1015, state ERROR; a following start clears err.
- Random in_valid gaps with 55 bytes -> data written only on handshakes; 0x01@62; 0xB8@63; num_blocks=1.
- rst asserted during PADZERO -> ram_we, busy, done, err drop to 0 at once; a subsequent "abc" run produces correct output.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Loads a byte-stream message into the byte-addressed SHA-256 message RAM,
//   then appends the standard padding: 0x80, zero fill up to the next
//   address a with a mod 64 == 56, and the 64-bit big-endian bit length.
//   One RAM write is issued per cycle. The block count is reported on done.
//
// Optional feature (macro SHA_PAD_LEN_OUT_EN):
//   When defined, adds output msg_len_bytes[10:0]. It carries the message
//   length in bytes, loads on done, holds until the next start and resets
//   to 0. When undefined, the port and its register do not exist.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            pulse; starts a new message (IDLE, DONE or ERROR only)
//   in_valid/in_data message byte stream; in_ready is high only in LOAD
//   in_end           end-of-message strobe (LOAD only)
//   ram_we/ram_waddr/ram_wdata   byte write port of the message RAM
//   busy             high while loading or padding
//   done             one-cycle pulse once the padded message is in RAM
//   num_blocks       number of 512-bit blocks, valid from done to next start
//   err              sticky overflow flag, cleared by start or rst
module sha256_msg_padder #(
  parameter int RAM_BYTES     = 1024,
  parameter int MAX_MSG_BYTES = RAM_BYTES - 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        in_end,
  output logic        ram_we,
  output logic [9:0]  ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic        busy,
  output logic        done,
  output logic [4:0]  num_blocks,
  output logic        err
`ifdef SHA_PAD_LEN_OUT_EN
  ,
  output logic [10:0] msg_len_bytes
`endif
);

  if ((RAM_BYTES % 64) != 0) begin : g_bad_ram_size
    $error("RAM_BYTES must be a multiple of 64");
  end

  localparam logic [10:0] MAX_N = 11'(MAX_MSG_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD80,
    S_PADZERO,
    S_LEN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [10:0] n;        // message bytes accepted so far
  logic [10:0] addr;     // write address during PADZERO and LEN
  logic [10:0] n_nx;
  logic [10:0] addr_nx;
  logic        accept;
  logic        overflow;

  // Byte k (0 = most significant) of the 64-bit bit length 8*nb.
  // Shift amount is 8*(7-k); for a 3-bit k, 7-k equals ~k.
  function automatic logic [7:0] len_byte(input logic [10:0] nb, input logic [2:0] k);
    logic [63:0] l;
    logic [5:0]  sh;
    l  = {50'd0, nb, 3'd0};
    sh = {~k, 3'b000};
    return 8'(l >> sh);
  endfunction

  assign n_nx     = n + 11'd1;
  assign addr_nx  = addr + 11'd1;
  assign accept   = (state == S_LOAD) && in_valid;
  assign overflow = accept && (n == MAX_N);

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_PAD80) ||
                    (state == S_PADZERO) || (state == S_LEN);

  // Write port: data bytes pass straight through on the handshake; padding
  // bytes come from the pad states. Decoded from registered state only, so
  // an asynchronous reset removes any write immediately.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    case (state)
      S_LOAD: begin
        if (accept && !overflow) begin
          ram_we    = 1'b1;
          ram_waddr = n[9:0];
          ram_wdata = in_data;
        end
      end
      S_PAD80: begin
        ram_we    = 1'b1;
        ram_waddr = n[9:0];
        ram_wdata = 8'h80;
      end
      S_PADZERO: begin
        ram_we    = 1'b1;
        ram_waddr = addr[9:0];
        ram_wdata = 8'h00;
      end
      S_LEN: begin
        // Length field starts on an 8-byte boundary, so addr[2:0] is the byte index.
        ram_we    = 1'b1;
        ram_waddr = addr[9:0];
        ram_wdata = len_byte(n, addr[2:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      n          <= '0;
      addr       <= '0;
      done       <= 1'b0;
      num_blocks <= '0;
      err        <= 1'b0;
`ifdef SHA_PAD_LEN_OUT_EN
      msg_len_bytes <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LOAD;
            n          <= '0;
            err        <= 1'b0;
            num_blocks <= '0;
`ifdef SHA_PAD_LEN_OUT_EN
            msg_len_bytes <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (overflow) begin
            err   <= 1'b1;
            state <= S_ERROR;
          end else begin
            // A byte coinciding with in_end is counted before padding starts.
            if (accept) n <= n_nx;
            if (in_end) state <= S_PAD80;
          end
        end
        S_PAD80: begin
          addr  <= n_nx;
          state <= (n_nx[5:0] == 6'd56) ? S_LEN : S_PADZERO;
        end
        S_PADZERO: begin
          addr <= addr_nx;
          if (addr_nx[5:0] == 6'd56) state <= S_LEN;
        end
        S_LEN: begin
          addr <= addr_nx;
          if (addr[2:0] == 3'd7) begin
            state      <= S_DONE;
            done       <= 1'b1;
            num_blocks <= addr_nx[10:6];  // (a+8)/64
`ifdef SHA_PAD_LEN_OUT_EN
            msg_len_bytes <= n;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: each message's expected RAM writes
// and block count are computed from the padding rules and queued; a monitor
// compares every DUT write and done pulse against the queues.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_end = 1'b0;
  logic        in_ready;
  logic        ram_we;
  logic [9:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic        busy;
  logic        done;
  logic [4:0]  num_blocks;
  logic        err;
`ifdef SHA_PAD_LEN_OUT_EN
  logic [10:0] msg_len_bytes;
`endif

  sha256_msg_padder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .in_end(in_end), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .num_blocks(num_blocks),
    .err(err)
`ifdef SHA_PAD_LEN_OUT_EN
    , .msg_len_bytes(msg_len_bytes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  int   exp_nb[$];
  int   exp_last[$];
  int   exp_len[$];
  logic [7:0] msg[$];

  logic       prev_done = 1'b0;
  logic       last_we = 1'b0;
  logic [9:0] last_addr = '0;
  wr_t        mon_e;
  int         mon_nb;
  int         mon_la;
  int         mon_len;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: message bytes, 0x80, zeros, then 8*n as 64-bit big-endian,
  // padded to the next multiple of 64 bytes.
  task automatic model(input int upto);
    int n;
    int padded;
    longint unsigned l;
    n      = msg.size();
    padded = ((n + 9 + 63) / 64) * 64;
    l      = longint'(n) * 8;
    for (int i = 0; i < n; i++) exp_q.push_back(wr_t'{10'(i), msg[i]});
    exp_q.push_back(wr_t'{10'(n), 8'h80});
    for (int a = n + 1; a < padded - 8; a++) exp_q.push_back(wr_t'{10'(a), 8'h00});
    for (int k = 0; k < 8; k++)
      exp_q.push_back(wr_t'{10'(padded - 8 + k), 8'(l >> (8 * (7 - k)))});
    exp_nb.push_back(padded / 64);
    exp_last.push_back(padded - 1);
    exp_len.push_back(n);
    // Optionally truncate the tail for runs that are interrupted.
    if (upto >= 0) begin
      while (exp_q.size() > upto) void'(exp_q.pop_back());
      void'(exp_nb.pop_back());
      void'(exp_last.pop_back());
      void'(exp_len.pop_back());
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
      last_we   = 1'b0;
    end else begin
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%02h, no write expected", ram_waddr, ram_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", ram_waddr, mon_e.a);
          check("wr_data", ram_wdata, mon_e.d);
        end
      end
      if (done) begin
        if (exp_nb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1, none expected");
        end else begin
          mon_nb  = exp_nb.pop_front();
          mon_la  = exp_last.pop_front();
          mon_len = exp_len.pop_front();
          check("num_blocks", num_blocks, mon_nb);
          check("done_after_last_write", last_we ? longint'(last_addr) : -1, mon_la);
          check("done_pulse_width", prev_done, 0);
`ifdef SHA_PAD_LEN_OUT_EN
          check("msg_len_bytes", msg_len_bytes, mon_len);
`endif
        end
      end
      prev_done = done;
      last_we   = ram_we;
      last_addr = ram_waddr;
    end
  end

  task automatic fill_random(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic drive(input int gap_pct, input bit coincide, input bit send_end);
    int gaps;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < msg.size(); i++) begin
      gaps = 0;
      while (gaps < 8 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        gaps++;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      in_end   = coincide && (i == msg.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_end   = 1'b0;
    end
    if (send_end && (!coincide || msg.size() == 0)) begin
      in_end = 1'b1;
      @(posedge clk); #1;
      in_end = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    #1;
    check({name, "_writes_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_err"}, err, 0);
  endtask

  task automatic run_msg(input string name, input int gap_pct, input bit coincide);
    model(-1);
    drive(gap_pct, coincide, 1'b1);
    wait_done(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_num_blocks", num_blocks, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // "abc"
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg("abc", 0, 1'b0);

    // Empty message
    msg.delete();
    run_msg("empty", 0, 1'b0);

    // 56 bytes, in_end with the last byte: spills into a second block
    fill_random(56);
    run_msg("len56", 0, 1'b1);

    // 55 bytes with random gaps: exactly fits one block
    fill_random(55);
    run_msg("len55_gaps", 50, 1'b0);

    // Random lengths, gaps and end alignment
    for (int r = 0; r < 6; r++) begin
      fill_random($urandom_range(0, 300));
      run_msg("random", $urandom_range(0, 60), 1'($urandom_range(0, 1)));
    end

    // Largest message
    fill_random(1015);
    run_msg("max", 0, 1'b0);

    // Overflow: byte 1016 must not be written
    fill_random(1016);
    model(1015);
    drive(0, 1'b0, 1'b0);
    check("ovf_err", err, 1);
    check("ovf_in_ready", in_ready, 0);
    check("ovf_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("ovf_writes_left", exp_q.size(), 0);
    check("ovf_err_sticky", err, 1);
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg("after_ovf", 0, 1'b0);

    // Reset during PADZERO
    model(10);  // data 0..2, 0x80@3, zeros 4..9
    drive(0, 1'b0, 1'b1);
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    check("midrst_reached_padzero", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check("midrst_ram_we", ram_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_msg("abc_after_rst", 0, 1'b0);

    check("no_pending_done", exp_nb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
